// File: rtl/writeback_seq_pkg.sv
// Shared definitions for the writeback sequencer: register file size,
// index/data widths, sequencer state encoding and the queued request format.
package writeback_seq_pkg;

   localparam int NREG_DEFAULT = 16;
   localparam int MAX_NREG     = 16;
   localparam int IDX_W        = 4;
   localparam int DATA_W       = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WIPE = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // One-hot decode of a register index over the largest supported register
   // file; callers truncate to their own register count, which naturally
   // drops indices that fall outside it.
   function automatic logic [MAX_NREG-1:0] idxOneHot(input logic [IDX_W-1:0] idx);
      logic [MAX_NREG-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/writeback_seq_wb_fifo.sv
// Small request FIFO for the writeback sequencer. Power-of-two depth so the
// pointers wrap on their own; push and pop may coincide at any occupancy.
module wb_fifo
   import writeback_seq_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    clr,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wrPtr_q;
   logic [PTR_W-1:0]   rdPtr_q;
   logic [CNT_W-1:0]   count_q;
   logic               doPush;
   logic               doPop;

   // Qualify the strobes so an over-eager caller can never corrupt the state:
   // a push into a full FIFO is only allowed when a pop frees a slot.
   always_comb begin
      doPop  = pop && !empty;
      doPush = push && (!full || doPop);
   end

   // Storage array carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr_q] <= din;
      end
   end

   // Pointer and occupancy bookkeeping, cleared synchronously.
   always_ff @(posedge clk) begin
      if (clr) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (doPop && !doPush) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign dout  = mem[rdPtr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/writeback_seq.sv
// Writeback sequencer: queues register-write requests and issues them one
// per cycle as a registered one-hot enable plus data, and on request walks
// every register writing zero once queued writes have drained.
module writeback_seq
   import writeback_seq_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int NREG  = NREG_DEFAULT
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [IDX_W-1:0]  req_idx,
   input  logic [DATA_W-1:0] req_data,
   input  logic              wipe_req,
   output logic [NREG-1:0]   wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy
);

   wb_state_e          state_q, state_d;
   logic               wipePend_q, wipePend_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [NREG-1:0]    wbEn_q, wbEn_d;
   logic [DATA_W-1:0]  wbData_q, wbData_d;

   wb_req_t            fifoIn;
   wb_req_t            fifoHead;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               fifoPush;
   logic               fifoPop;
   logic               readyInt;

   // Handshake: drain the FIFO every idle cycle, accept new requests unless a
   // wipe is running or pending, and let a full FIFO accept when it also pops.
   always_comb begin
      fifoPop  = (state_q == ST_IDLE) && !fifoEmpty;
      readyInt = !clr && (state_q == ST_IDLE) && !wipePend_q && (!fifoFull || fifoPop);
      fifoPush = req_valid && readyInt;
      fifoIn   = '{idx: req_idx, data: req_data};
   end

   wb_fifo #(
      .DEPTH (DEPTH)
   ) uFifo (
      .clk   (clk),
      .clr   (clr),
      .push  (fifoPush),
      .pop   (fifoPop),
      .din   (fifoIn),
      .dout  (fifoHead),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   // Next-state and next-output logic for the idle/wipe sequencer.
   always_comb begin
      state_d    = state_q;
      wipePend_d = wipePend_q;
      cnt_d      = cnt_q;
      wbEn_d     = '0;
      wbData_d   = wbData_q;
      case (state_q)
         ST_IDLE: begin
            if (wipe_req) begin
               wipePend_d = 1'b1;
            end
            if (fifoPop) begin
               wbEn_d   = NREG'(idxOneHot(fifoHead.idx));
               wbData_d = fifoHead.data;
            end
            if (wipePend_q && fifoEmpty) begin
               state_d    = ST_WIPE;
               wipePend_d = 1'b0;
               cnt_d      = '0;
            end
         end
         ST_WIPE: begin
            wbEn_d   = NREG'(idxOneHot(cnt_q));
            wbData_d = '0;
            if (cnt_q == IDX_W'(NREG - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, wipe counter and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= ST_IDLE;
         wipePend_q <= 1'b0;
         cnt_q      <= '0;
         wbEn_q     <= '0;
         wbData_q   <= '0;
      end else begin
         state_q    <= state_d;
         wipePend_q <= wipePend_d;
         cnt_q      <= cnt_d;
         wbEn_q     <= wbEn_d;
         wbData_q   <= wbData_d;
      end
   end

   assign req_ready = readyInt;
   assign wb_en     = wbEn_q;
   assign wb_data   = wbData_q;
   assign busy      = (state_q == ST_WIPE) || wipePend_q || !fifoEmpty;

endmodule

// File: tb/tb_writeback_seq.sv
// Directed bench for the writeback sequencer: a 16-register instance carries
// most scenarios, a 12-register instance shares its stimulus so that
// out-of-range indices can be observed.
module tb_writeback_seq;

   logic        clk;
   logic        clr;
   logic        req_valid;
   logic [3:0]  req_idx;
   logic [31:0] req_data;
   logic        wipe_req;

   logic        ready16;
   logic [15:0] wbEn16;
   logic [31:0] wbData16;
   logic        busy16;

   logic        ready12;
   logic [11:0] wbEn12;
   logic [31:0] wbData12;
   logic        busy12;

   int          checks;
   int          errors;

   writeback_seq #(.DEPTH(2), .NREG(16)) dut (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (ready16),
      .req_idx   (req_idx),
      .req_data  (req_data),
      .wipe_req  (wipe_req),
      .wb_en     (wbEn16),
      .wb_data   (wbData16),
      .busy      (busy16)
   );

   writeback_seq #(.DEPTH(2), .NREG(12)) dut12 (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (ready12),
      .req_idx   (req_idx),
      .req_data  (req_data),
      .wipe_req  (wipe_req),
      .wb_en     (wbEn12),
      .wb_data   (wbData12),
      .busy      (busy12)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [3:0] idx,
                                input logic [31:0] data, input logic wipe);
      req_valid = valid;
      req_idx   = idx;
      req_data  = data;
      wipe_req  = wipe;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      logic [31:0] dat [3];
      logic [15:0] acc;
      checks = 0;
      errors = 0;
      clr    = 1'b1;
      applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      checkOutput("ready_during_clr", 32'(ready16), 32'h0);
      tick();
      tick();
      checkOutput("reset_wb_en", 32'(wbEn16), 32'h0);
      checkOutput("reset_wb_data", wbData16, 32'h0);
      checkOutput("reset_busy", 32'(busy16), 32'h0);
      clr = 1'b0;
      #1;
      checkOutput("ready_after_clr", 32'(ready16), 32'h1);

      // Single write: accepted in cycle t, visible in cycle t+2 only.
      applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
      #1;
      checkOutput("single_ready", 32'(ready16), 32'h1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      #1;
      checkOutput("single_t1_en", 32'(wbEn16), 32'h0);
      checkOutput("single_t1_busy", 32'(busy16), 32'h1);
      tick();
      checkOutput("single_t2_en", 32'(wbEn16), 32'h0000_0020);
      checkOutput("single_t2_data", wbData16, 32'hDEADBEEF);
      tick();
      checkOutput("single_t3_en", 32'(wbEn16), 32'h0);
      checkOutput("single_t3_hold", wbData16, 32'hDEADBEEF);
      checkOutput("single_t3_busy", 32'(busy16), 32'h0);

      // Back-to-back writes to R1..R3; push and pop overlap each cycle.
      dat[0] = 32'h1111_0001;
      dat[1] = 32'h2222_0002;
      dat[2] = 32'h3333_0003;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            applyStimulus(1'b1, 4'(i + 1), dat[i], 1'b0);
         end else begin
            applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
         end
         #1;
         if (i < 3) begin
            checkOutput($sformatf("b2b_ready_%0d", i), 32'(ready16), 32'h1);
         end
         if (i >= 2) begin
            checkOutput($sformatf("b2b_en_%0d", i), 32'(wbEn16), 32'h1 << (i - 1));
            checkOutput($sformatf("b2b_data_%0d", i), wbData16, dat[i - 2]);
         end
         tick();
      end
      checkOutput("b2b_idle_en", 32'(wbEn16), 32'h0);

      // Two queued writes, then a wipe pulse alongside the second one.
      applyStimulus(1'b1, 4'd7, 32'hAAAA_0007, 1'b0);
      tick();
      applyStimulus(1'b1, 4'd8, 32'hBBBB_0008, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      #1;
      checkOutput("wipe_w2_en", 32'(wbEn16), 32'h0000_0080);
      checkOutput("wipe_w2_data", wbData16, 32'hAAAA_0007);
      checkOutput("wipe_w2_ready", 32'(ready16), 32'h0);
      checkOutput("wipe_w2_busy", 32'(busy16), 32'h1);
      tick();
      checkOutput("wipe_w3_en", 32'(wbEn16), 32'h0000_0100);
      checkOutput("wipe_w3_data", wbData16, 32'hBBBB_0008);
      checkOutput("wipe_w3_ready", 32'(ready16), 32'h0);
      tick();
      checkOutput("wipe_w4_en", 32'(wbEn16), 32'h0);
      checkOutput("wipe_w4_busy", 32'(busy16), 32'h1);
      checkOutput("wipe_w4_ready", 32'(ready16), 32'h0);
      for (int k = 0; k < 16; k++) begin
         tick();
         applyStimulus(1'b0, 4'd0, 32'h0, (k == 3));
         checkOutput($sformatf("wipe_en_%0d", k), 32'(wbEn16), 32'h1 << k);
         checkOutput($sformatf("wipe_data_%0d", k), wbData16, 32'h0);
         if (k < 15) begin
            checkOutput($sformatf("wipe_ready_%0d", k), 32'(ready16), 32'h0);
         end else begin
            checkOutput("wipe_end_busy", 32'(busy16), 32'h0);
         end
      end
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      tick();
      checkOutput("wipe_after_en", 32'(wbEn16), 32'h0);
      checkOutput("wipe_after_busy", 32'(busy16), 32'h0);
      tick();
      checkOutput("wipe_ignored_en", 32'(wbEn16), 32'h0);

      // Reset while the wipe counter sits at 7.
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      repeat (8) tick();
      checkOutput("midwipe_en_cnt6", 32'(wbEn16), 32'h0000_0040);
      clr = 1'b1;
      #1;
      checkOutput("midwipe_clr_ready", 32'(ready16), 32'h0);
      tick();
      clr = 1'b0;
      #1;
      checkOutput("midwipe_post_en", 32'(wbEn16), 32'h0);
      checkOutput("midwipe_post_busy", 32'(busy16), 32'h0);
      checkOutput("midwipe_post_ready", 32'(ready16), 32'h1);
      acc = '0;
      repeat (20) begin
         tick();
         acc |= wbEn16;
      end
      checkOutput("midwipe_no_more_en", 32'(acc), 32'h0);

      // Index 15: dropped by the 12-register instance, R15 on the 16-register one.
      applyStimulus(1'b1, 4'hF, 32'hCAFE_F00D, 1'b0);
      #1;
      checkOutput("idxF_ready12", 32'(ready12), 32'h1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      #1;
      checkOutput("idxF_busy12_queued", 32'(busy12), 32'h1);
      tick();
      checkOutput("idxF_en12", 32'(wbEn12), 32'h0);
      checkOutput("idxF_busy12_drained", 32'(busy12), 32'h0);
      checkOutput("idxF_en16", 32'(wbEn16), 32'h0000_8000);
      tick();
      checkOutput("idxF_en12_after", 32'(wbEn12), 32'h0);

      // Index 0 is issued like any other register.
      applyStimulus(1'b1, 4'h0, 32'h0000_1234, 1'b0);
      tick();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
      tick();
      checkOutput("idx0_en", 32'(wbEn16), 32'h0000_0001);
      checkOutput("idx0_data", wbData16, 32'h0000_1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
